// File: rtl/switch_event_decoder.sv
// switch_event_decoder: turns a debounced switch level into press, release,
// hold and auto-repeat events, presented on a valid/ack interface.
// All timing advances on clk_enable ticks; the event register runs every clk.
module switch_event_decoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_enable,
  input  logic        switch_level,
  input  logic [15:0] hold_period,
  input  logic [15:0] repeat_period,
  input  logic        event_ack,
  output logic        event_valid,
  output logic [1:0]  event_type,
  output logic        event_overrun,
  output logic        switch_pressed
);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_HOLD    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  // Counter decrement that sticks at zero instead of wrapping.
  function automatic logic [15:0] dec_sat(input logic [15:0] value);
    dec_sat = (value != 16'h0) ? (value - 16'h1) : 16'h0;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [15:0] counter;
  logic [15:0] counter_nxt;
  logic        raise;
  logic [1:0]  raise_type;
  logic        ev_free;
  logic        valid_nxt;
  logic [1:0]  type_nxt;
  logic        overrun_nxt;

  // Next state, counter and raised event; only tick cycles may change anything.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    raise       = 1'b0;
    raise_type  = EV_PRESS;
    if (clk_enable) begin
      case (state)
        ST_RELEASED: begin
          if (switch_level) begin
            state_nxt   = ST_PRESSED;
            counter_nxt = hold_period;
            raise       = 1'b1;
            raise_type  = EV_PRESS;
          end
        end
        ST_PRESSED: begin
          if (!switch_level) begin
            state_nxt  = ST_RELEASED;
            raise      = 1'b1;
            raise_type = EV_RELEASE;
          end else if (counter == 16'h0) begin
            state_nxt   = ST_HELD;
            counter_nxt = repeat_period;
            raise       = 1'b1;
            raise_type  = EV_HOLD;
          end else begin
            counter_nxt = dec_sat(counter);
          end
        end
        ST_HELD: begin
          // Release wins over a repeat due on the same tick.
          if (!switch_level) begin
            state_nxt  = ST_RELEASED;
            raise      = 1'b1;
            raise_type = EV_RELEASE;
          end else if ((repeat_period != 16'h0) && (counter == 16'h0)) begin
            counter_nxt = repeat_period;
            raise       = 1'b1;
            raise_type  = EV_REPEAT;
          end else begin
            counter_nxt = dec_sat(counter);
          end
        end
        default: begin
          state_nxt   = ST_RELEASED;
          counter_nxt = 16'h0;
        end
      endcase
    end
  end

  // Event slot: load when free, drop with overrun when occupied, clear on ack.
  always_comb begin
    ev_free     = !event_valid || event_ack;
    valid_nxt   = event_valid;
    type_nxt    = event_type;
    overrun_nxt = event_overrun;
    if (raise) begin
      if (ev_free) begin
        valid_nxt = 1'b1;
        type_nxt  = raise_type;
      end
    end else if (event_ack) begin
      valid_nxt = 1'b0;
    end
    if (raise && !ev_free) begin
      overrun_nxt = 1'b1;
    end else if (event_valid && event_ack) begin
      overrun_nxt = 1'b0;
    end
  end

  // State and tick counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_RELEASED;
      counter <= 16'h0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  // Event outputs and the pressed flag, kept aligned with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_valid    <= 1'b0;
      event_type     <= EV_PRESS;
      event_overrun  <= 1'b0;
      switch_pressed <= 1'b0;
    end else begin
      event_valid    <= valid_nxt;
      event_type     <= type_nxt;
      event_overrun  <= overrun_nxt;
      switch_pressed <= (state_nxt != ST_RELEASED);
    end
  end

endmodule
